// File: rtl/settings_bus_arb_pkg.sv
// Shared types and default widths for the settings bus arbiter.
package settings_bus_arb_pkg;

    // Arbiter FSM states; encodings are fixed so state dumps stay readable.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWaitRb = 2'd2,
        StAck    = 2'd3
    } arb_state_e;

    localparam int unsigned NumReqDefault   = 4;
    localparam int unsigned SrAwidthDefault = 8;
    localparam int unsigned SrDwidthDefault = 32;
    localparam int unsigned RbAwidthDefault = 8;
    localparam int unsigned RbDwidthDefault = 64;
    localparam int unsigned TimeoutDefault  = 65535;
    localparam int unsigned WdogCntWidth    = 16;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one past last_grant
// and wraps modulo NUM_REQ; the parent registers the result.
module rr_arbiter
    import settings_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    localparam int unsigned IdxW   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    grant_idx,
    output logic               any_req
);

    logic        found;
    int unsigned cand;

    assign any_req = |req;

    // First pending requester after last_grant wins; last_grant itself is checked last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[IdxW'(cand)]) begin
                found               = 1'b1;
                grant[IdxW'(cand)]  = 1'b1;
                grant_idx           = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing one settings/readback bus among NUM_REQ requesters.
// Each transaction issues a one-cycle set_stb, holds rb_addr until rb_stb returns,
// then acknowledges the winner with the captured readback data.
// Optional readback watchdog: define SETTINGS_BUS_ARB_TIMEOUT_EN.
module settings_bus_arbiter
    import settings_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NumReqDefault,
    parameter int unsigned SR_AWIDTH = SrAwidthDefault,
    parameter int unsigned SR_DWIDTH = SrDwidthDefault,
    parameter int unsigned RB_AWIDTH = RbAwidthDefault,
    parameter int unsigned RB_DWIDTH = RbDwidthDefault,
    parameter int unsigned TIMEOUT   = TimeoutDefault
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_stb,
    input  logic [NUM_REQ*SR_AWIDTH-1:0]   req_set_addr,
    input  logic [NUM_REQ*SR_DWIDTH-1:0]   req_set_data,
    input  logic [NUM_REQ*RB_AWIDTH-1:0]   req_rb_addr,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [RB_DWIDTH-1:0]           req_rb_data,
    output logic                           req_timeout,
    output logic                           set_stb,
    output logic [SR_AWIDTH-1:0]           set_addr,
    output logic [SR_DWIDTH-1:0]           set_data,
    output logic [RB_AWIDTH-1:0]           rb_addr,
    input  logic                           rb_stb,
    input  logic [RB_DWIDTH-1:0]           rb_data
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);

    arb_state_e           state_q;
    logic [IdxW-1:0]      last_grant_q;
    logic [IdxW-1:0]      grant_idx_q;
    logic [NUM_REQ-1:0]   grant_oh_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IdxW-1:0]      arb_idx;
    logic                 arb_any;

    logic [SR_AWIDTH-1:0] sel_set_addr;
    logic [SR_DWIDTH-1:0] sel_set_data;
    logic [RB_AWIDTH-1:0] sel_rb_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_stb),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    // Slice the winning requester's fields out of the packed request buses.
    assign sel_set_addr = req_set_addr[arb_idx*SR_AWIDTH +: SR_AWIDTH];
    assign sel_set_data = req_set_data[arb_idx*SR_DWIDTH +: SR_DWIDTH];
    assign sel_rb_addr  = req_rb_addr[arb_idx*RB_AWIDTH +: RB_AWIDTH];

`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
    localparam logic [WdogCntWidth-1:0] WdogLimit = WdogCntWidth'(TIMEOUT - 1);
    logic [WdogCntWidth-1:0] wdog_cnt_q;
`else
    // No watchdog: a readback can never time out.
    assign req_timeout = 1'b0;
`endif

    // Transaction FSM; every bus-facing output is a register written here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            grant_idx_q  <= '0;
            grant_oh_q   <= '0;
            req_ack      <= '0;
            req_rb_data  <= '0;
            set_stb      <= 1'b0;
            set_addr     <= '0;
            set_data     <= '0;
            rb_addr      <= '0;
`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
            req_timeout  <= 1'b0;
            wdog_cnt_q   <= '0;
`endif
        end else begin
            // Completion outputs are only ever high for the single ACK cycle.
            req_ack     <= '0;
            req_rb_data <= '0;
`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
            req_timeout <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        grant_idx_q <= arb_idx;
                        grant_oh_q  <= arb_grant;
                        set_stb     <= 1'b1;
                        set_addr    <= sel_set_addr;
                        set_data    <= sel_set_data;
                        rb_addr     <= sel_rb_addr;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    set_stb  <= 1'b0;
                    set_addr <= '0;
                    set_data <= '0;
                    if (rb_stb) begin
                        req_ack     <= grant_oh_q;
                        req_rb_data <= rb_data;
                        rb_addr     <= '0;
                        state_q     <= StAck;
                    end else begin
                        state_q     <= StWaitRb;
`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
                        wdog_cnt_q  <= '0;
`endif
                    end
                end
                StWaitRb: begin
                    // A real readback beats watchdog expiry in the same cycle.
                    if (rb_stb) begin
                        req_ack     <= grant_oh_q;
                        req_rb_data <= rb_data;
                        rb_addr     <= '0;
                        state_q     <= StAck;
                    end
`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
                    else if (wdog_cnt_q == WdogLimit) begin
                        req_ack     <= grant_oh_q;
                        req_rb_data <= '0;
                        req_timeout <= 1'b1;
                        rb_addr     <= '0;
                        state_q     <= StAck;
                    end else begin
                        wdog_cnt_q  <= wdog_cnt_q + 1'b1;
                    end
`endif
                end
                StAck: begin
                    last_grant_q <= grant_idx_q;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed self-checking bench for settings_bus_arbiter (NUM_REQ=4, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_settings_bus_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_stb;
    logic [31:0]  req_set_addr;
    logic [127:0] req_set_data;
    logic [31:0]  req_rb_addr;
    logic [3:0]   req_ack;
    logic [63:0]  req_rb_data;
    logic         req_timeout;
    logic         set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [7:0]   rb_addr;
    logic         rb_stb;
    logic [63:0]  rb_data;

    int n_cmp = 0;
    int n_err = 0;

    settings_bus_arbiter #(
        .NUM_REQ   (4),
        .SR_AWIDTH (8),
        .SR_DWIDTH (32),
        .RB_AWIDTH (8),
        .RB_DWIDTH (64),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_stb      (req_stb),
        .req_set_addr (req_set_addr),
        .req_set_data (req_set_data),
        .req_rb_addr  (req_rb_addr),
        .req_ack      (req_ack),
        .req_rb_data  (req_rb_data),
        .req_timeout  (req_timeout),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .rb_addr      (rb_addr),
        .rb_stb       (rb_stb),
        .rb_data      (rb_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, 64'(req_ack), 64'h0);
        check_eq({tag, "_rbdata"}, req_rb_data, 64'h0);
        check_eq({tag, "_tmo"}, 64'(req_timeout), 64'h0);
        check_eq({tag, "_setstb"}, 64'(set_stb), 64'h0);
        check_eq({tag, "_setaddr"}, 64'(set_addr), 64'h0);
        check_eq({tag, "_setdata"}, 64'(set_data), 64'h0);
        check_eq({tag, "_rbaddr"}, 64'(rb_addr), 64'h0);
    endtask

    task automatic set_req(input int idx, input logic [7:0] a, input logic [31:0] d,
                           input logic [7:0] r);
        req_set_addr[idx*8 +: 8]  = a;
        req_set_data[idx*32 +: 32] = d;
        req_rb_addr[idx*8 +: 8]   = r;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Hard stop in case the DUT wedges the bench.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ack_seen;
        reset_n      = 1'b0;
        req_stb      = '0;
        req_set_addr = '0;
        req_set_data = '0;
        req_rb_addr  = '0;
        rb_stb       = 1'b0;
        rb_data      = '0;
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h40 + i), 32'(32'hC0DE0000 + i), 8'(8'h20 + i));

        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Stray readback strobe in IDLE must be ignored.
        tick();
        rb_stb  = 1'b1;
        rb_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        rb_stb  = 1'b0;
        check_eq("stray_ack", 64'(req_ack), 64'h0);
        check_eq("stray_setstb", 64'(set_stb), 64'h0);
        tick();
        check_eq("stray_ack2", 64'(req_ack), 64'h0);
        check_eq("stray_rbaddr", 64'(rb_addr), 64'h0);

        // Single request from requester 2; readback two cycles after set_stb.
        set_req(2, 8'h10, 32'hDEADBEEF, 8'h05);
        req_stb = 4'b0100;
        tick(); // ISSUE
        check_eq("single_setstb", 64'(set_stb), 64'h1);
        check_eq("single_setaddr", 64'(set_addr), 64'h10);
        check_eq("single_setdata", 64'(set_data), 64'hDEADBEEF);
        check_eq("single_rbaddr", 64'(rb_addr), 64'h05);
        set_req(2, 8'hFF, 32'h0, 8'hAA); // late change must not leak through
        tick(); // WAIT_RB
        check_eq("single_wait_setstb", 64'(set_stb), 64'h0);
        check_eq("single_wait_setaddr", 64'(set_addr), 64'h0);
        check_eq("single_wait_setdata", 64'(set_data), 64'h0);
        check_eq("single_wait_rbaddr", 64'(rb_addr), 64'h05);
        check_eq("single_wait_ack", 64'(req_ack), 64'h0);
        tick(); // still WAIT_RB; slave answers now
        check_eq("single_wait2_rbaddr", 64'(rb_addr), 64'h05);
        check_eq("single_wait2_ack", 64'(req_ack), 64'h0);
        rb_stb  = 1'b1;
        rb_data = 64'h1122334455667788;
        tick(); // ACK
        rb_stb = 1'b0;
        check_eq("single_ack", 64'(req_ack), 64'h4);
        check_eq("single_rbdata", req_rb_data, 64'h1122334455667788);
        check_eq("single_tmo", 64'(req_timeout), 64'h0);
        check_eq("single_ack_rbaddr", 64'(rb_addr), 64'h0);
        req_stb = '0;
        tick();
        check_eq("single_post_ack", 64'(req_ack), 64'h0);
        check_eq("single_post_rbdata", req_rb_data, 64'h0);

        // Round robin from reset with same-cycle readback: acks at cycles 2,5,8,11,14.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h40 + i), 32'(32'hC0DE0000 + i), 8'(8'h20 + i));
        req_stb = 4'hF;
        rb_stb  = 1'b1;
        rb_data = 64'h0123456789ABCDEF;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c % 3 == 2) begin
                check_eq($sformatf("rr_ack_c%0d", c), 64'(req_ack), 64'(4'b0001 << ((c / 3) % 4)));
                check_eq($sformatf("rr_rbdata_c%0d", c), req_rb_data, 64'h0123456789ABCDEF);
            end else begin
                check_eq($sformatf("rr_noack_c%0d", c), 64'(req_ack), 64'h0);
            end
            check_eq($sformatf("rr_setstb_c%0d", c), 64'(set_stb), 64'(c % 3 == 1));
        end
        req_stb = '0;
        rb_stb  = 1'b0;
        tick();
        check_eq("rr_idle_setstb", 64'(set_stb), 64'h0);

        // Silent slave: requester 3 alone.
        set_req(3, 8'h77, 32'h5555AAAA, 8'h33);
        req_stb = 4'b1000;
`ifdef SETTINGS_BUS_ARB_TIMEOUT_EN
        ack_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ack_seen == 0 && req_ack != 4'b0) begin
                ack_seen = c;
                check_eq("wdog_ack", 64'(req_ack), 64'h8);
                check_eq("wdog_rbdata", req_rb_data, 64'h0);
                check_eq("wdog_tmo", 64'(req_timeout), 64'h1);
                req_stb = '0;
            end
        end
        check_eq("wdog_ack_cycle", 64'(ack_seen), 64'd18);

        // Readback arriving exactly at expiry wins over the timeout.
        req_stb = 4'b1000;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 17) begin
                rb_stb  = 1'b1;
                rb_data = 64'hCAFEF00D12345678;
            end
            if (c < 18) begin
                check_eq($sformatf("wdog_pri_noack_c%0d", c), 64'(req_ack), 64'h0);
            end else begin
                check_eq("wdog_pri_ack", 64'(req_ack), 64'h8);
                check_eq("wdog_pri_rbdata", req_rb_data, 64'hCAFEF00D12345678);
                check_eq("wdog_pri_tmo", 64'(req_timeout), 64'h0);
            end
        end
        rb_stb  = 1'b0;
        req_stb = '0;
        tick();
        req_stb = 4'b1000;
        repeat (4) tick(); // parked in WAIT_RB
`else
        ack_seen = 0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (req_ack != 4'b0) ack_seen++;
        end
        check_eq("nowdog_no_ack", 64'(ack_seen), 64'h0);
`endif
        check_eq("midrst_pre_rbaddr", 64'(rb_addr), 64'h33);

        // Reset in WAIT_RB clears outputs at once; requester 0 is served first afterwards.
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        check_eq("midrst_hold_ack", 64'(req_ack), 64'h0);
        set_req(0, 8'h01, 32'h0000BEEF, 8'h02);
        req_stb = 4'b1001;
        rb_stb  = 1'b1;
        rb_data = 64'h00000000000000AB;
        reset_n = 1'b1;
        tick();
        check_eq("midrst_setstb", 64'(set_stb), 64'h1);
        check_eq("midrst_setaddr", 64'(set_addr), 64'h01);
        tick();
        check_eq("midrst_ack", 64'(req_ack), 64'h1);
        check_eq("midrst_rbdata", req_rb_data, 64'hAB);
        req_stb = '0;
        rb_stb  = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
